// File: rtl/rtc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : rtc_pkg                                                      |
// | Description : Calendar field limits, month lengths and Gregorian helpers   |
// |               shared by the advance path and the load validation.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package rtc_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [3:0] MONT_MAX = 4'd12;

    localparam logic [4:0] DAYS_LONG     = 5'd31;
    localparam logic [4:0] DAYS_SHORT    = 5'd30;
    localparam logic [4:0] DAYS_FEB      = 5'd28;
    localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;

    // Callers zero-extend their year to 32 bits, so any year width up to 32
    // is evaluated on its full value.
    localparam int YEAR_ARG_W = 32;

    function automatic logic is_leap(input logic [YEAR_ARG_W-1:0] year);
        logic div4;
        logic div100;
        logic div400;
        div4   = (year[1:0] == 2'b00);
        div100 = ((year % 32'd100) == 32'd0);
        div400 = ((year % 32'd400) == 32'd0);
        return (div4 && !div100) || div400;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] mont,
                                                 input logic [YEAR_ARG_W-1:0] year);
        logic [4:0] days;
        case (mont)
            4'd2:                      days = is_leap(year) ? DAYS_FEB_LEAP : DAYS_FEB;
            4'd4, 4'd6, 4'd9, 4'd11:   days = DAYS_SHORT;
            default:                   days = DAYS_LONG;
        endcase
        return days;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_prescaler.sv
// +----------------------------------------------------------------------------+
// | Module      : rtc_prescaler                                                |
// | Description : Divides the system clock down to one tick per second while   |
// |               running; holds its count while paused; clearable on load.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rtc_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    // A one-bit counter is kept even for CLK_DIV=1; it simply stays at zero.
    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and wrap only while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rtc_calendar.sv
// +----------------------------------------------------------------------------+
// | Module      : rtc_calendar                                                 |
// | Description : Prescaled real-time calendar clock with Gregorian leap years,|
// |               validated load port and minute-resolution alarm.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rtc_calendar
    import rtc_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int YEAR_W     = 13,
    parameter int YEAR_RESET = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              set_valid,
    input  logic [5:0]        set_sec,
    input  logic [5:0]        set_min,
    input  logic [4:0]        set_hour,
    input  logic [4:0]        set_day,
    input  logic [3:0]        set_mont,
    input  logic [YEAR_W-1:0] set_year,
    input  logic              alarm_en,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        mont,
    output logic [YEAR_W-1:0] year,
    output logic              sec_pulse,
    output logic              set_err,
    output logic              alarm_hit
);

    logic [5:0]        sec_q,  sec_d;
    logic [5:0]        min_q,  min_d;
    logic [4:0]        hour_q, hour_d;
    logic [4:0]        day_q,  day_d;
    logic [3:0]        mont_q, mont_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              sec_pulse_q, sec_pulse_d;
    logic              set_err_q,   set_err_d;
    logic              alarm_hit_q, alarm_hit_d;

    logic       tick;
    logic       load_ok;
    logic       load_take;
    logic [4:0] dim_cur;
    logic [4:0] dim_set;
    logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mont_wrap;

    // An accepted load restarts the second so the loaded time is shown for a full period.
    rtc_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clear (load_take),
        .tick  (tick)
    );

    assign dim_cur = days_in_month(mont_q, YEAR_ARG_W'(year_q));
    assign dim_set = days_in_month(set_mont, YEAR_ARG_W'(set_year));

    assign load_ok = (set_sec <= SEC_MAX) && (set_min <= MIN_MAX) && (set_hour <= HOUR_MAX)
                  && (set_mont != 4'd0) && (set_mont <= MONT_MAX)
                  && (set_day != 5'd0) && (set_day <= dim_set);
    assign load_take = set_valid && load_ok;

    // Carry chain: each field rolls only when every lower field rolls.
    assign sec_wrap  = (sec_q == SEC_MAX);
    assign min_wrap  = sec_wrap  && (min_q == MIN_MAX);
    assign hour_wrap = min_wrap  && (hour_q == HOUR_MAX);
    assign day_wrap  = hour_wrap && (day_q == dim_cur);
    assign mont_wrap = day_wrap  && (mont_q == MONT_MAX);

    // Next calendar state: a valid load overrides a coincident tick.
    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        day_d       = day_q;
        mont_d      = mont_q;
        year_d      = year_q;
        sec_pulse_d = 1'b0;
        alarm_hit_d = 1'b0;
        set_err_d   = set_valid && !load_ok;

        if (load_take) begin
            sec_d  = set_sec;
            min_d  = set_min;
            hour_d = set_hour;
            day_d  = set_day;
            mont_d = set_mont;
            year_d = set_year;
        end else if (tick) begin
            sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
            if (sec_wrap)  min_d  = min_wrap  ? 6'd0 : min_q + 6'd1;
            if (min_wrap)  hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
            if (hour_wrap) day_d  = day_wrap  ? 5'd1 : day_q + 5'd1;
            if (day_wrap)  mont_d = mont_wrap ? 4'd1 : mont_q + 4'd1;
            if (mont_wrap) year_d = year_q + YEAR_W'(1);
            sec_pulse_d = 1'b1;
            // Out-of-range alarm settings can never equal a counted field.
            alarm_hit_d = alarm_en && (hour_d == alarm_hour) && (min_d == alarm_min)
                       && (sec_d == 6'd0);
        end
    end

    // Calendar and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            day_q       <= 5'd1;
            mont_q      <= 4'd1;
            year_q      <= YEAR_W'(YEAR_RESET);
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            mont_q      <= mont_d;
            year_q      <= year_d;
            sec_pulse_q <= sec_pulse_d;
            set_err_q   <= set_err_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign day       = day_q;
    assign mont      = mont_q;
    assign year      = year_q;
    assign sec_pulse = sec_pulse_q;
    assign set_err   = set_err_q;
    assign alarm_hit = alarm_hit_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_calendar.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_rtc_calendar                                              |
// | Description : Self-checking bench for rtc_calendar; two instances          |
// |               (CLK_DIV=1 and CLK_DIV=4) against a behavioural model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rtc_calendar;

    localparam int YW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, run, set_valid, alarm_en;
    logic [5:0]    set_sec, set_min, alarm_min;
    logic [4:0]    set_hour, set_day, alarm_hour;
    logic [3:0]    set_mont;
    logic [YW-1:0] set_year;

    logic [5:0]    a_sec, a_min, b_sec, b_min;
    logic [4:0]    a_hour, a_day, b_hour, b_day;
    logic [3:0]    a_mont, b_mont;
    logic [YW-1:0] a_year, b_year;
    logic          a_sp, a_se, a_ah, b_sp, b_se, b_ah;

    int checks = 0;
    int errors = 0;

    rtc_calendar #(.CLK_DIV(1), .YEAR_W(YW), .YEAR_RESET(2000)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .set_valid(set_valid),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour), .set_day(set_day),
        .set_mont(set_mont), .set_year(set_year), .alarm_en(alarm_en),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .sec(a_sec), .min(a_min), .hour(a_hour), .day(a_day), .mont(a_mont), .year(a_year),
        .sec_pulse(a_sp), .set_err(a_se), .alarm_hit(a_ah)
    );

    rtc_calendar #(.CLK_DIV(4), .YEAR_W(YW), .YEAR_RESET(2000)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .set_valid(set_valid),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour), .set_day(set_day),
        .set_mont(set_mont), .set_year(set_year), .alarm_en(alarm_en),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .sec(b_sec), .min(b_min), .hour(b_hour), .day(b_day), .mont(b_mont), .year(b_year),
        .sec_pulse(b_sp), .set_err(b_se), .alarm_hit(b_ah)
    );

    // ------------------------------------------------------------------ model
    typedef struct packed {
        int sec, min, hour, day, mont, year, cnt;
        int sp, se, ah;
    } ms_t;

    ms_t m1, m4;

    function automatic int leap_m(int y);
        if (y % 400 == 0) return 1;
        if (y % 100 == 0) return 0;
        return (y % 4 == 0) ? 1 : 0;
    endfunction

    function automatic int mdays(int m, int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && leap_m(y) == 1) return 29;
        return t[m-1];
    endfunction

    function automatic ms_t mreset();
        ms_t r;
        r = '0;
        r.day = 1; r.mont = 1; r.year = 2000;
        return r;
    endfunction

    // One clock edge of the calendar, using the inputs currently driven.
    function automatic ms_t mstep(ms_t s, int div);
        ms_t n;
        int  tod;
        bit  tick, ok;
        n = s; n.sp = 0; n.se = 0; n.ah = 0;
        tick = run && (s.cnt == div - 1);
        if (run) n.cnt = (s.cnt + 1) % div;
        if (set_valid) begin
            ok = 0;
            if (set_sec <= 59 && set_min <= 59 && set_hour <= 23 &&
                set_mont >= 1 && set_mont <= 12 && set_day >= 1)
                ok = (int'(set_day) <= mdays(int'(set_mont), int'(set_year)));
            if (ok) begin
                n.sec = set_sec; n.min = set_min; n.hour = set_hour;
                n.day = set_day; n.mont = set_mont; n.year = int'(set_year);
                n.cnt = 0;
                return n;
            end
            n.se = 1;
        end
        if (tick) begin
            tod = s.hour * 3600 + s.min * 60 + s.sec + 1;
            if (tod == 86400) begin
                tod = 0;
                n.day = s.day + 1;
                if (n.day > mdays(s.mont, s.year)) begin
                    n.day = 1;
                    n.mont = s.mont + 1;
                    if (n.mont > 12) begin
                        n.mont = 1;
                        n.year = (s.year + 1) % (1 << YW);
                    end
                end
            end
            n.hour = tod / 3600;
            n.min  = (tod / 60) % 60;
            n.sec  = tod % 60;
            n.sp   = 1;
            n.ah   = (alarm_en && n.hour == int'(alarm_hour) &&
                      n.min == int'(alarm_min) && n.sec == 0) ? 1 : 0;
        end
        return n;
    endfunction

    // ------------------------------------------------------------ checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("d1.sec",  32'(a_sec),  m1.sec);   chk("d4.sec",  32'(b_sec),  m4.sec);
        chk("d1.min",  32'(a_min),  m1.min);   chk("d4.min",  32'(b_min),  m4.min);
        chk("d1.hour", 32'(a_hour), m1.hour);  chk("d4.hour", 32'(b_hour), m4.hour);
        chk("d1.day",  32'(a_day),  m1.day);   chk("d4.day",  32'(b_day),  m4.day);
        chk("d1.mont", 32'(a_mont), m1.mont);  chk("d4.mont", 32'(b_mont), m4.mont);
        chk("d1.year", 32'(a_year), m1.year);  chk("d4.year", 32'(b_year), m4.year);
        chk("d1.sec_pulse", 32'(a_sp), m1.sp); chk("d4.sec_pulse", 32'(b_sp), m4.sp);
        chk("d1.set_err",   32'(a_se), m1.se); chk("d4.set_err",   32'(b_se), m4.se);
        chk("d1.alarm_hit", 32'(a_ah), m1.ah); chk("d4.alarm_hit", 32'(b_ah), m4.ah);
    endtask

    task automatic cyc();
        m1 = mstep(m1, 1);
        m4 = mstep(m4, 4);
        @(posedge clk);
        #1;
        cmp_all();
        set_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load(input int y, input int mo, input int d,
                        input int h, input int mi, input int s);
        set_year = YW'(y); set_mont = 4'(mo); set_day = 5'(d);
        set_hour = 5'(h);  set_min  = 6'(mi); set_sec = 6'(s);
        set_valid = 1'b1;
        cyc();
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst_n = 1'b1; run = 1'b0; set_valid = 1'b0; alarm_en = 1'b0;
        set_sec = '0; set_min = '0; set_hour = '0; set_day = 5'd1; set_mont = 4'd1;
        set_year = YW'(2000); alarm_hour = '0; alarm_min = '0;
        m1 = mreset(); m4 = mreset();
        #1 rst_n = 1'b0;
        #3 cmp_all();
        @(negedge clk) rst_n = 1'b1;

        // Free run after reset
        run = 1'b1;
        cycles(12);
        chk("div4.sec_after12", 32'(b_sec), 3);
        cycles(48);
        chk("div1.min_after60", 32'(a_min), 1);
        chk("div1.sec_after60", 32'(a_sec), 0);
        chk("div4.sec_after60", 32'(b_sec), 15);

        // Pause and resume mid-second
        cycles(2);
        run = 1'b0;
        cycles(10);
        run = 1'b1;
        cycles(9);

        // Leap and year rollovers (valid load coincides with a dut1 tick)
        load(2024, 2, 28, 23, 59, 59);
        chk("load_exact.sec", 32'(a_sec), 59);
        cycles(4);
        chk("leap2024.day", 32'(b_day), 29); chk("leap2024.mont", 32'(b_mont), 2);
        load(2100, 2, 28, 23, 59, 59); cycles(4);
        chk("noleap2100.day", 32'(b_day), 1); chk("noleap2100.mont", 32'(b_mont), 3);
        load(2000, 2, 28, 23, 59, 59); cycles(4);
        chk("leap2000.day", 32'(b_day), 29);
        load(2023, 12, 31, 23, 59, 59); cycles(4);
        chk("newyear.year", 32'(b_year), 2024); chk("newyear.hour", 32'(b_hour), 0);
        load(8191, 12, 31, 23, 59, 59); cycles(4);
        chk("wrap.year", 32'(b_year), 0); chk("wrap.mont", 32'(b_mont), 1);

        // Rejected loads while paused
        run = 1'b0;
        load(2023, 4, 31, 10, 0, 0);
        chk("err.apr31", 32'(a_se), 1);
        cyc();
        load(2023, 2, 29, 10, 0, 0);
        chk("err.feb29", 32'(b_se), 1);
        load(2023, 3, 1, 24, 0, 0);
        chk("err.hour24", 32'(a_se), 1);
        cycles(2);

        // Alarm
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        run = 1'b1;
        load(2024, 5, 5, 7, 29, 59);
        cyc();
        chk("alarm.d1_hit", 32'(a_ah), 1);
        cycles(3);
        chk("alarm.d4_hit", 32'(b_ah), 1);
        run = 1'b0;
        load(2024, 5, 5, 7, 30, 0);
        chk("alarm.load_nohit", 32'(a_ah), 0);
        alarm_en = 1'b0; run = 1'b1;
        load(2024, 5, 5, 7, 29, 59);
        cycles(4);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 m1 = mreset(); m4 = mreset();
        cmp_all();
        @(negedge clk) rst_n = 1'b1;

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) begin
                alarm_en   = $urandom_range(0, 3) != 0;
                alarm_hour = 5'(($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : m1.hour);
                alarm_min  = 6'(($urandom_range(0, 9) == 0) ? $urandom_range(60, 63)
                                                           : (m1.min + 1) % 60);
            end
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    set_year = YW'($urandom_range(0, (1 << YW) - 1));
                    set_mont = 4'($urandom_range(0, 15));
                    set_day  = 5'($urandom_range(0, 31));
                    set_hour = 5'($urandom_range(0, 31));
                    set_min  = 6'($urandom_range(0, 63));
                    set_sec  = 6'($urandom_range(0, 63));
                end else begin
                    case ($urandom_range(0, 4))
                        0: set_year = YW'(2000);
                        1: set_year = YW'(2100);
                        2: set_year = YW'(2024);
                        3: set_year = YW'(2023);
                        default: set_year = YW'(8191);
                    endcase
                    set_mont = 4'($urandom_range(1, 12));
                    set_day  = 5'($urandom_range(27, 31));
                    set_hour = 5'(($urandom_range(0, 1) == 0) ? 23 : alarm_hour);
                    set_min  = 6'(($urandom_range(0, 1) == 0) ? 59 : alarm_min - 6'd1);
                    set_sec  = 6'($urandom_range(50, 59));
                end
                set_valid = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
